// File: rtl/mux_4x1_pkg.sv
// ---------------------------------------------------------------------------
// mux_4x1_pkg
// Shared types and constants for the mux_4x1 selector.
//   sel_t        : 2-bit select, {s1,s0}
//   SEL_A..SEL_D : select codes for data inputs a..d
//   SEL_CNT_MAX  : saturation value of the optional select-change counter
//                  (present only when MUX_4X1_SEL_STATS_EN is defined)
// ---------------------------------------------------------------------------
package mux_4x1_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

    localparam logic [15:0] SEL_CNT_MAX = 16'hFFFF;

    // Saturating increment used by the select-change counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == SEL_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mux_4x1_mux_2x1.sv
// ---------------------------------------------------------------------------
// mux_2x1
// WIDTH-bit 2:1 combinational selector, leaf of the mux_4x1 tree.
// Ports:
//   in0  : data selected when sel=0
//   in1  : data selected when sel=1
//   sel  : select
//   y    : selected data
// An unknown sel propagates as all-X on y rather than merging in0/in1,
// so simulation never hides a bad select behind matching data bits.
// ---------------------------------------------------------------------------
module mux_2x1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            1'b0:    y = in0;
            1'b1:    y = in1;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/mux_4x1.sv
// ---------------------------------------------------------------------------
// mux_4x1
// 4-to-1 selector with a combinational output and a registered copy.
// Ports:
//   clk     : rising-edge clock, registered path only
//   rst     : asynchronous active-high reset (registered path only)
//   a,b,c,d : WIDTH-bit data inputs, selected by {s1,s0} = 00/01/10/11
//   s0, s1  : select LSB / MSB
//   out     : combinational selected data (not affected by clk or rst)
//   out_q   : out registered on clk
//   sel_chg : registered pulse, {s1,s0} differs from last sampled select
//   sel_cnt : saturating count of sel_chg pulses
//             (only when MUX_4X1_SEL_STATS_EN is defined)
// Optional feature macro: MUX_4X1_SEL_STATS_EN
// ---------------------------------------------------------------------------
module mux_4x1
    import mux_4x1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] out,
`ifdef MUX_4X1_SEL_STATS_EN
    output logic [15:0]      sel_cnt,
`endif
    output logic [WIDTH-1:0] out_q,
    output logic             sel_chg
);

    logic [WIDTH-1:0] ab_y;
    logic [WIDTH-1:0] cd_y;

    // Leaf stage on s0, root stage on s1.
    mux_2x1 #(.WIDTH(WIDTH)) u_mux_ab (
        .in0 (a),
        .in1 (b),
        .sel (s0),
        .y   (ab_y)
    );

    mux_2x1 #(.WIDTH(WIDTH)) u_mux_cd (
        .in0 (c),
        .in1 (d),
        .sel (s0),
        .y   (cd_y)
    );

    mux_2x1 #(.WIDTH(WIDTH)) u_mux_root (
        .in0 (ab_y),
        .in1 (cd_y),
        .sel (s1),
        .y   (out)
    );

    // -----------------------------------------------------------------------
    // Registered path
    // -----------------------------------------------------------------------
    sel_t             sel_cur;
    sel_t             sel_d;
    sel_t             sel_q;
    logic [WIDTH-1:0] out_d;
    logic             sel_chg_d;
    logic             sel_chg_q;

    assign sel_cur = {s1, s0};

    always_comb begin
        out_d     = out;
        sel_d     = sel_cur;
        // After reset sel_q holds SEL_A, so the first edge compares to 00.
        sel_chg_d = (sel_cur != sel_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            sel_q     <= SEL_A;
            sel_chg_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            sel_q     <= sel_d;
            sel_chg_q <= sel_chg_d;
        end
    end

    assign sel_chg = sel_chg_q;

`ifdef MUX_4X1_SEL_STATS_EN
    // Counts edges where the compare is true, i.e. one per sel_chg pulse.
    logic [15:0] sel_cnt_d;
    logic [15:0] sel_cnt_q;

    always_comb begin
        sel_cnt_d = sel_cnt_q;
        if (sel_chg_d) begin
            sel_cnt_d = sat_inc(sel_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_cnt_q <= '0;
        end else begin
            sel_cnt_q <= sel_cnt_d;
        end
    end

    assign sel_cnt = sel_cnt_q;
`endif

endmodule

// File: tb/tb_mux_4x1.sv
// ---------------------------------------------------------------------------
// tb_mux_4x1
// Directed self-checking bench for mux_4x1 (WIDTH=1): a vector table for the
// combinational select, then hand-written sequences for the registered path,
// asynchronous reset and, when MUX_4X1_SEL_STATS_EN is defined, the counter.
// ---------------------------------------------------------------------------
module tb_mux_4x1;

    localparam int WIDTH = 1;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a, b, c, d;
    logic             s0, s1;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             sel_chg;
`ifdef MUX_4X1_SEL_STATS_EN
    logic [15:0]      sel_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    mux_4x1 #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .s0      (s0),
        .s1      (s1),
        .out     (out),
`ifdef MUX_4X1_SEL_STATS_EN
        .sel_cnt (sel_cnt),
`endif
        .out_q   (out_q),
        .sel_chg (sel_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic       a, b, c, d;
        logic       s1, s0;
        logic       exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // inputs, select, expected out
        vecs.push_back('{"zero_sel00",  0,0,0,0, 0,0, 0});
        vecs.push_back('{"a_sel00",     1,0,0,0, 0,0, 1});
        vecs.push_back('{"b_sel01",     0,1,0,0, 0,1, 1});
        vecs.push_back('{"c_sel10",     0,0,1,0, 1,0, 1});
        vecs.push_back('{"d_sel11",     0,0,0,1, 1,1, 1});
        vecs.push_back('{"a_only_sel01",1,0,0,0, 0,1, 0});
        vecs.push_back('{"b_only_sel10",0,1,0,0, 1,0, 0});
        vecs.push_back('{"c_only_sel11",0,0,1,0, 1,1, 0});
        vecs.push_back('{"d_only_sel00",0,0,0,1, 0,0, 0});
        vecs.push_back('{"iso_1010_s11",1,0,1,0, 1,1, 0});
        vecs.push_back('{"iso_0101_s01",0,1,0,1, 0,1, 1});
        vecs.push_back('{"ones_sel00",  1,1,1,1, 0,0, 1});
        vecs.push_back('{"ones_sel01",  1,1,1,1, 0,1, 1});
        vecs.push_back('{"ones_sel10",  1,1,1,1, 1,0, 1});
        vecs.push_back('{"ones_sel11",  1,1,1,1, 1,1, 1});
        vecs.push_back('{"neg_c_sel10", 1,1,0,1, 1,0, 0});

        rst = 1'b1;
        {a, b, c, d} = '0;
        {s1, s0} = 2'b00;
        #2;
        check("reset_out_q",   32'(out_q),   32'h0);
        check("reset_sel_chg", 32'(sel_chg), 32'h0);
`ifdef MUX_4X1_SEL_STATS_EN
        check("reset_sel_cnt", 32'(sel_cnt), 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Combinational table, applied between edges.
        foreach (vecs[i]) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; c = vecs[i].c; d = vecs[i].d;
            s1 = vecs[i].s1; s0 = vecs[i].s0;
            #1;
            check(vecs[i].name, 32'(out), 32'(vecs[i].exp));
        end

        // Registered path: settle at sel=00 with only d high, then jump to 11.
        @(negedge clk);
        a = 0; b = 0; c = 0; d = 1; {s1, s0} = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("hold00_out_q",   32'(out_q),   32'h0);
        check("hold00_sel_chg", 32'(sel_chg), 32'h0);
        @(negedge clk);
        {s1, s0} = 2'b11;
        #1;
        check("sel11_out_now",   32'(out),   32'h1);
        check("sel11_out_q_old", 32'(out_q), 32'h0);
        @(posedge clk); #1;
        check("sel11_out_q_next", 32'(out_q),   32'h1);
        check("sel11_chg_pulse",  32'(sel_chg), 32'h1);
        @(posedge clk); #1;
        check("sel11_chg_drop",   32'(sel_chg), 32'h0);
        check("sel11_out_q_hold", 32'(out_q),   32'h1);

        // Asynchronous reset between edges; out keeps tracking inputs.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_q",   32'(out_q),   32'h0);
        check("arst_sel_chg", 32'(sel_chg), 32'h0);
        check("arst_out",     32'(out),     32'h1);
        @(posedge clk); #1;
        check("arst_hold_out_q", 32'(out_q), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_out_q",   32'(out_q),   32'h1);
        // sel_q restarted at 00, so holding 11 shows as a change once.
        check("rel_sel_chg", 32'(sel_chg), 32'h1);
        @(posedge clk); #1;
        check("rel_sel_chg_drop", 32'(sel_chg), 32'h0);

        // Simultaneous data and select change: out_q takes the combined value.
        @(negedge clk);
        a = 0; b = 1; c = 0; d = 0; {s1, s0} = 2'b01;
        @(posedge clk); #1;
        check("simul_out_q", 32'(out_q), 32'h1);

`ifdef MUX_4X1_SEL_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        {s1, s0} = 2'b00;
        #1;
        check("cnt_rst", 32'(sel_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s0 = ~s0;
        end
        @(posedge clk); #1;
        check("cnt_five", 32'(sel_cnt), 32'd5);
        // Drive the counter to saturation by toggling, then keep toggling.
        for (int k = 0; k < 65535 - 5 + 4; k++) begin
            @(negedge clk);
            s0 = ~s0;
        end
        @(posedge clk); #1;
        check("cnt_sat", 32'(sel_cnt), 32'hFFFF);
        @(negedge clk);
        s0 = ~s0;
        @(posedge clk); #1;
        check("cnt_sat_hold", 32'(sel_cnt), 32'hFFFF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("cnt_rst_after", 32'(sel_cnt), 32'h0);
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
